// File: rtl/bcd_pulse_sender.sv
// Decadic pulse-train sender: each BCD digit becomes a burst of that many pulses
// (digit 0 sends ten). Digits go out MSD first, separated by an inter-digit gap.
module bcd_pulse_sender #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int GAP_CYCLES  = 16,
  parameter int DIGITS      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  ready,
  output logic                  pulse_out,
  output logic [3:0]            cur_count,
  output logic                  digit_done,
  output logic                  done,
  output logic                  err
);

  localparam int MAX_HL  = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int MAX_CYC = (MAX_HL > GAP_CYCLES) ? MAX_HL : GAP_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  state_t              r_state,  w_state_nxt;
  logic [CNT_W-1:0]    r_cnt,    w_cnt_nxt;
  logic [3:0]          r_left,   w_left_nxt;
  logic [IDX_W-1:0]    r_idx,    w_idx_nxt;
  logic [4*DIGITS-1:0] r_digits, w_digits_nxt;
  logic [3:0]          r_cur_count, w_cc_nxt;
  logic                r_pulse, r_ready, r_digit_done, r_done, r_err;
  logic                w_dd_nxt, w_done_nxt, w_err_nxt;
  logic                w_bad;

  function automatic logic [3:0] pulses_for(input logic [3:0] digit);
    return (digit == 4'd0) ? 4'd10 : digit;
  endfunction

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  // NOTE: every next-state value gets a default before the case so no path
  // leaves it unassigned; a missing default here would infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_left_nxt   = r_left;
    w_idx_nxt    = r_idx;
    w_digits_nxt = r_digits;
    w_cc_nxt     = r_cur_count;
    w_dd_nxt     = 1'b0;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_digits_nxt = bcd_in;
            w_idx_nxt    = IDX_W'(DIGITS - 1);
            w_left_nxt   = pulses_for(bcd_in[4*DIGITS-1 -: 4]);
            w_cnt_nxt    = HIGH_LOAD;
            w_cc_nxt     = 4'd1;
            w_state_nxt  = S_HIGH;
          end
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_cnt_nxt   = LOW_LOAD;
          w_state_nxt = S_LOW;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_LOW: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (r_left > 4'd1) begin
          w_left_nxt  = r_left - 4'd1;
          w_cnt_nxt   = HIGH_LOAD;
          w_cc_nxt    = r_cur_count + 4'd1;
          w_state_nxt = S_HIGH;
        end else begin
          w_dd_nxt = 1'b1;
          if (r_idx != '0) begin
            // Shift so the next digit always sits in the top nibble.
            w_digits_nxt = r_digits << 4;
            w_idx_nxt    = r_idx - IDX_W'(1);
            w_cnt_nxt    = GAP_LOAD;
            w_cc_nxt     = 4'd0;
            w_state_nxt  = S_GAP;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          w_left_nxt  = pulses_for(r_digits[4*DIGITS-1 -: 4]);
          w_cnt_nxt   = HIGH_LOAD;
          w_cc_nxt    = 4'd1;
          w_state_nxt = S_HIGH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the latched digit register is reset as well, so a mid-burst
      // reset really discards the transfer rather than leaving stale data.
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_left       <= 4'd0;
      r_idx        <= '0;
      r_digits     <= '0;
      r_cur_count  <= 4'd0;
      r_pulse      <= 1'b0;
      r_ready      <= 1'b1;
      r_digit_done <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_left       <= w_left_nxt;
      r_idx        <= w_idx_nxt;
      r_digits     <= w_digits_nxt;
      r_cur_count  <= w_cc_nxt;
      r_pulse      <= (w_state_nxt == S_HIGH);
      r_ready      <= (w_state_nxt == S_IDLE);
      r_digit_done <= w_dd_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign ready      = r_ready;
  assign pulse_out  = r_pulse;
  assign cur_count  = r_cur_count;
  assign digit_done = r_digit_done;
  assign done       = r_done;
  assign err        = r_err;

endmodule
